// File: rtl/cpld_uart_responder.sv
// rtl/cpld_uart_responder.sv - CPLD-style UART bridge: parallel rdn/wrn bus handshake to 8N1 serial line
module cpld_uart_responder #(
  parameter int CLK_FREQ = 11059200,
  parameter int BAUD     = 115200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rdn,
  input  logic       wrn,
  input  logic [7:0] bus_data_i,
  output logic [7:0] bus_data_o,
  output logic       bus_data_oe,
  output logic       dataready,
  output logic       tbre,
  output logic       tsre,
  output logic       txd,
  input  logic       rxd,
  output logic       overrun,
  output logic       frame_err
);

  localparam int DIV = CLK_FREQ / BAUD;
  localparam int CW  = $clog2(DIV);
  localparam logic [CW-1:0] DIV_LAST = CW'(DIV - 1);
  localparam logic [CW-1:0] HALF     = CW'(DIV / 2);

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_BREAK} rx_state_t;

  logic       rdn_s1_q, rdn_s2_q, rdn_prev_q;
  logic       wrn_s1_q, wrn_s2_q, wrn_prev_q;
  logic       rxd_s1_q, rxd_s2_q, rxd_prev_q;
  logic [7:0] wdata_s1_q, wdata_s2_q;

  tx_state_t  tx_state_q, tx_state_d;
  logic [CW-1:0] tx_cnt_q, tx_cnt_d;
  logic [2:0] tx_bit_q, tx_bit_d;
  logic [7:0] tx_shift_q, tx_shift_d;
  logic [7:0] tx_hold_q, tx_hold_d;
  logic       tbre_q, tbre_d;
  logic       tsre_q, tsre_d;

  rx_state_t  rx_state_q, rx_state_d;
  logic [CW-1:0] rx_cnt_q, rx_cnt_d;
  logic [2:0] rx_bit_q, rx_bit_d;
  logic [7:0] rx_shift_q, rx_shift_d;
  logic [7:0] rx_hold_q, rx_hold_d;
  logic       dready_q, dready_d;
  logic       overrun_q, overrun_d;
  logic       frame_err_q, frame_err_d;

  logic rdn_rise, wrn_rise, rxd_fall, wr_accept;

  // Two-flop synchronisers plus a delayed copy for edge detection; idle levels are high.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdn_s1_q   <= 1'b1;
      rdn_s2_q   <= 1'b1;
      rdn_prev_q <= 1'b1;
      wrn_s1_q   <= 1'b1;
      wrn_s2_q   <= 1'b1;
      wrn_prev_q <= 1'b1;
      rxd_s1_q   <= 1'b1;
      rxd_s2_q   <= 1'b1;
      rxd_prev_q <= 1'b1;
      wdata_s1_q <= 8'h00;
      wdata_s2_q <= 8'h00;
    end else begin
      rdn_s1_q   <= rdn;
      rdn_s2_q   <= rdn_s1_q;
      rdn_prev_q <= rdn_s2_q;
      wrn_s1_q   <= wrn;
      wrn_s2_q   <= wrn_s1_q;
      wrn_prev_q <= wrn_s2_q;
      rxd_s1_q   <= rxd;
      rxd_s2_q   <= rxd_s1_q;
      rxd_prev_q <= rxd_s2_q;
      wdata_s1_q <= bus_data_i;
      wdata_s2_q <= wdata_s1_q;
    end
  end

  assign rdn_rise  = rdn_s2_q & ~rdn_prev_q;
  assign wrn_rise  = wrn_s2_q & ~wrn_prev_q;
  assign rxd_fall  = ~rxd_s2_q & rxd_prev_q;
  assign wr_accept = wrn_rise & tbre_q;

  // TX next state: holding-register write capture and start/data/stop bit sequencing.
  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    tx_hold_d  = tx_hold_q;
    tbre_d     = tbre_q;
    tsre_d     = tsre_q;
    if (wr_accept) begin
      tx_hold_d = wdata_s2_q;
      tbre_d    = 1'b0;
    end
    case (tx_state_q)
      TX_IDLE: begin
        tx_cnt_d = '0;
        if (!tbre_q) begin
          tx_shift_d = tx_hold_q;
          tbre_d     = 1'b1;
          tsre_d     = 1'b0;
          tx_state_d = TX_START;
        end
      end
      TX_START: begin
        if (tx_cnt_q == DIV_LAST) begin
          tx_cnt_d   = '0;
          tx_bit_d   = 3'd0;
          tx_state_d = TX_DATA;
        end else begin
          tx_cnt_d = tx_cnt_q + 1'b1;
        end
      end
      TX_DATA: begin
        if (tx_cnt_q == DIV_LAST) begin
          tx_cnt_d   = '0;
          tx_shift_d = {1'b0, tx_shift_q[7:1]};
          if (tx_bit_q == 3'd7) tx_state_d = TX_STOP;
          else                  tx_bit_d   = tx_bit_q + 1'b1;
        end else begin
          tx_cnt_d = tx_cnt_q + 1'b1;
        end
      end
      TX_STOP: begin
        if (tx_cnt_q == DIV_LAST) begin
          tx_cnt_d = '0;
          if (wr_accept) begin
            // Write arriving on the last stop cycle goes straight into the shifter.
            tx_shift_d = wdata_s2_q;
            tbre_d     = 1'b1;
            tx_state_d = TX_START;
          end else if (!tbre_q) begin
            tx_shift_d = tx_hold_q;
            tbre_d     = 1'b1;
            tx_state_d = TX_START;
          end else begin
            tsre_d     = 1'b1;
            tx_state_d = TX_IDLE;
          end
        end else begin
          tx_cnt_d = tx_cnt_q + 1'b1;
        end
      end
      default: tx_state_d = TX_IDLE;
    endcase
  end

  // TX state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_state_q <= TX_IDLE;
      tx_cnt_q   <= '0;
      tx_bit_q   <= 3'd0;
      tx_shift_q <= 8'h00;
      tx_hold_q  <= 8'h00;
      tbre_q     <= 1'b1;
      tsre_q     <= 1'b1;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_shift_q <= tx_shift_d;
      tx_hold_q  <= tx_hold_d;
      tbre_q     <= tbre_d;
      tsre_q     <= tsre_d;
    end
  end

  // RX next state: start qualification, centre sampling, holding-register load and error pulses.
  always_comb begin
    rx_state_d  = rx_state_q;
    rx_cnt_d    = rx_cnt_q;
    rx_bit_d    = rx_bit_q;
    rx_shift_d  = rx_shift_q;
    rx_hold_d   = rx_hold_q;
    dready_d    = dready_q;
    overrun_d   = 1'b0;
    frame_err_d = 1'b0;
    if (rdn_rise) dready_d = 1'b0;
    case (rx_state_q)
      RX_IDLE: begin
        rx_cnt_d = '0;
        if (rxd_fall) begin
          // The edge-detect cycle counts as the first cycle of the start bit.
          rx_cnt_d   = CW'(1);
          rx_state_d = RX_START;
        end
      end
      RX_START: begin
        if (rx_cnt_q == HALF) begin
          rx_cnt_d = '0;
          rx_bit_d = 3'd0;
          if (rxd_s2_q) rx_state_d = RX_IDLE;
          else          rx_state_d = RX_DATA;
        end else begin
          rx_cnt_d = rx_cnt_q + 1'b1;
        end
      end
      RX_DATA: begin
        if (rx_cnt_q == DIV_LAST) begin
          rx_cnt_d   = '0;
          rx_shift_d = {rxd_s2_q, rx_shift_q[7:1]};
          if (rx_bit_q == 3'd7) rx_state_d = RX_STOP;
          else                  rx_bit_d   = rx_bit_q + 1'b1;
        end else begin
          rx_cnt_d = rx_cnt_q + 1'b1;
        end
      end
      RX_STOP: begin
        if (rx_cnt_q == DIV_LAST) begin
          rx_cnt_d = '0;
          if (rxd_s2_q) begin
            rx_state_d = RX_IDLE;
            if (!dready_q || rdn_rise) begin
              rx_hold_d = rx_shift_q;
              dready_d  = 1'b1;
            end else begin
              overrun_d = 1'b1;
            end
          end else begin
            frame_err_d = 1'b1;
            rx_state_d  = RX_BREAK;
          end
        end else begin
          rx_cnt_d = rx_cnt_q + 1'b1;
        end
      end
      RX_BREAK: begin
        rx_cnt_d = '0;
        if (rxd_s2_q) rx_state_d = RX_IDLE;
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  // RX state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_state_q  <= RX_IDLE;
      rx_cnt_q    <= '0;
      rx_bit_q    <= 3'd0;
      rx_shift_q  <= 8'h00;
      rx_hold_q   <= 8'h00;
      dready_q    <= 1'b0;
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      rx_state_q  <= rx_state_d;
      rx_cnt_q    <= rx_cnt_d;
      rx_bit_q    <= rx_bit_d;
      rx_shift_q  <= rx_shift_d;
      rx_hold_q   <= rx_hold_d;
      dready_q    <= dready_d;
      overrun_q   <= overrun_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign txd         = (tx_state_q == TX_START) ? 1'b0 :
                       (tx_state_q == TX_DATA)  ? tx_shift_q[0] : 1'b1;
  assign tbre        = tbre_q;
  assign tsre        = tsre_q;
  assign bus_data_oe = ~rdn_s2_q;
  assign bus_data_o  = rx_hold_q;
  assign dataready   = dready_q;
  assign overrun     = overrun_q;
  assign frame_err   = frame_err_q;

endmodule
